// File: rtl/test_engine_packet_injector_pkg.sv
// Shared types and helpers for the test-engine packet injector and its flit FIFO.
package test_engine_packet_injector_pkg;

  localparam int CHANNEL_WIDTH = 32;

  typedef logic [CHANNEL_WIDTH-1:0] flit_t;

  // Counter width able to hold every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/test_engine_flit_fifo.sv
// Synchronous first-word-fall-through flit FIFO; count reports occupancy 0..DEPTH.
module test_engine_flit_fifo
  import test_engine_packet_injector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1'b1);
  endfunction

  // Flit storage; stale entries are never visible because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/test_engine_packet_injector.sv
// Edge-lane packet injector: buffers host flits and sends whole packets onto the
// mesh under credit-based flow control, with an optional idle gap after each packet.
module test_engine_packet_injector
  import test_engine_packet_injector_pkg::*;
#(
  parameter int PACKET_FLITS = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int CREDITS      = 4,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_WIDTH-1:0] host_din,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [CHANNEL_WIDTH-1:0] channel_dout,
  input  logic                     credit_in,
  output logic                     busy,
  output logic [15:0]              packets_sent,
  output logic                     credit_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int FCW = cnt_width(FIFO_DEPTH);
  localparam int CCW = cnt_width(CREDITS);
  localparam int IW  = cnt_width(PACKET_FLITS);
  localparam int GW  = 4;

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic [CCW-1:0] credit_cnt_r;
  logic [CCW-1:0] credit_nxt_s;
  logic [IW-1:0]  flit_idx_r;
  logic [GW-1:0]  gap_cnt_r;
  flit_t          channel_dout_r;
  logic           host_ready_r;
  logic           busy_r;
  logic [15:0]    packets_sent_r;
  logic           credit_error_r;

  logic           push_s;
  logic           send_s;
  logic           last_s;
  logic           credit_ovf_s;
  logic [FCW-1:0] fifo_count_s;
  logic [FCW-1:0] count_nxt_s;
  flit_t          fifo_dout_s;

  test_engine_flit_fifo #(
    .WIDTH (CHANNEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (send_s),
    .din   (host_din),
    .dout  (fifo_dout_s),
    .count (fifo_count_s)
  );

  // Handshake, send qualification and next credit count.
  always_comb begin
    push_s       = host_valid && host_ready_r;
    send_s       = (state_r == ST_SEND) && (credit_cnt_r != {CCW{1'b0}});
    last_s       = send_s && (flit_idx_r == IW'(PACKET_FLITS - 1));
    count_nxt_s  = fifo_count_s + FCW'(push_s) - FCW'(send_s);
    // A return that would exceed the downstream depth is dropped and flagged.
    credit_ovf_s = credit_in && (credit_cnt_r == CCW'(CREDITS)) && !send_s;
    if (credit_ovf_s) begin
      credit_nxt_s = credit_cnt_r;
    end else begin
      credit_nxt_s = credit_cnt_r + CCW'(credit_in) - CCW'(send_s);
    end
  end

  // Packet FSM; IDLE counts this cycle's push so a packet starts right after its last flit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_nxt_s >= FCW'(PACKET_FLITS)) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_s) begin
          state_nxt_s = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == {GW{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters, output register and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      credit_cnt_r   <= CCW'(CREDITS);
      flit_idx_r     <= {IW{1'b0}};
      gap_cnt_r      <= {GW{1'b0}};
      channel_dout_r <= {CHANNEL_WIDTH{1'b0}};
      host_ready_r   <= 1'b1;
      busy_r         <= 1'b0;
      packets_sent_r <= 16'd0;
      credit_error_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      credit_cnt_r <= credit_nxt_s;
      if (send_s) begin
        flit_idx_r <= last_s ? {IW{1'b0}} : flit_idx_r + IW'(1'b1);
      end
      if (last_s) begin
        gap_cnt_r      <= (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};
        packets_sent_r <= packets_sent_r + 16'd1;
      end else if ((state_r == ST_GAP) && (gap_cnt_r != {GW{1'b0}})) begin
        gap_cnt_r <= gap_cnt_r - GW'(1'b1);
      end
      channel_dout_r <= send_s ? fifo_dout_s : {CHANNEL_WIDTH{1'b0}};
      host_ready_r   <= count_nxt_s < FCW'(FIFO_DEPTH);
      busy_r         <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {FCW{1'b0}});
      if (credit_ovf_s) begin
        credit_error_r <= 1'b1;
      end
    end
  end

  assign host_ready   = host_ready_r;
  assign channel_dout = channel_dout_r;
  assign busy         = busy_r;
  assign packets_sent = packets_sent_r;
  assign credit_error = credit_error_r;

endmodule

// File: tb/tb_test_engine_packet_injector.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic scored
// against an in-order flit queue and a credit-budget invariant.
module tb_test_engine_packet_injector;
  import test_engine_packet_injector_pkg::*;

  localparam int CREDITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, host_valid, host_ready, credit_in, busy, credit_error;
  logic [31:0]  host_din, channel_dout;
  logic [15:0]  packets_sent;
  logic         g_reset, g_host_valid, g_host_ready, g_credit_in, g_busy, g_credit_error;
  logic [31:0]  g_host_din, g_channel_dout;
  logic [15:0]  g_packets_sent;

  test_engine_packet_injector dut (
    .clk(clk), .reset(reset), .host_din(host_din), .host_valid(host_valid),
    .host_ready(host_ready), .channel_dout(channel_dout), .credit_in(credit_in),
    .busy(busy), .packets_sent(packets_sent), .credit_error(credit_error)
  );

  test_engine_packet_injector #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .reset(g_reset), .host_din(g_host_din), .host_valid(g_host_valid),
    .host_ready(g_host_ready), .channel_dout(g_channel_dout), .credit_in(g_credit_in),
    .busy(g_busy), .packets_sent(g_packets_sent), .credit_error(g_credit_error)
  );

  int    tests_run = 0;
  int    tests_failed = 0;
  flit_t src_q[$];
  flit_t exp_q[$];
  int    rx_time[$];
  int    rx_total, ret_total, ret_pend, acc_total, now_cyc;
  bit    credit_en, rand_valid, rand_cred;
  int    g_t[10];
  int    g_v[10];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    reset = 1'b1; host_valid = 1'b0; host_din = 32'h0; credit_in = 1'b0;
    step();
    reset = 1'b0;
    src_q.delete(); exp_q.delete(); rx_time.delete();
    rx_total = 0; ret_total = 0; ret_pend = 0; acc_total = 0; now_cyc = 0;
    credit_en = 1'b0; rand_valid = 1'b0; rand_cred = 1'b0;
    check_eq("rst_dout", channel_dout, 32'h0);
    check_eq("rst_ready", 32'(host_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pkts", 32'(packets_sent), 32'd0);
    check_eq("rst_err", 32'(credit_error), 32'd0);
  endtask

  // One clock of host driver, downstream credit returner and output scoreboard.
  task automatic cycle_a();
    int ret_snap;
    host_valid = 1'b0;
    host_din   = 32'h0;
    if (src_q.size() > 0 && (!rand_valid || $urandom_range(3) != 0)) begin
      host_valid = 1'b1;
      host_din   = src_q[0];
    end
    ret_snap  = ret_total;
    credit_in = 1'b0;
    if (ret_pend > 0 && (!rand_cred || $urandom_range(1) == 0)) begin
      credit_in = 1'b1;
      ret_pend--;
      ret_total++;
    end
    if (host_valid && host_ready) begin
      exp_q.push_back(src_q.pop_front());
      acc_total++;
    end
    step();
    now_cyc++;
    if (channel_dout != 32'h0) begin
      rx_total++;
      rx_time.push_back(now_cyc);
      if (credit_en) ret_pend++;
      if (exp_q.size() == 0) check_eq("unexpected_flit", channel_dout, 32'h0);
      else check_eq("flit_order", channel_dout, exp_q.pop_front());
      check_eq("credit_limit", 32'(rx_total <= CREDITS + ret_snap), 32'd1);
    end
  endtask

  task automatic run_until_rx(input int target, input int budget);
    int b;
    b = 0;
    while (rx_total < target && b < budget) begin
      cycle_a();
      b++;
    end
  endtask

  initial begin
    int pushed, seen, retq;
    reset = 1'b1; g_reset = 1'b1;
    host_valid = 1'b0; host_din = 32'h0; credit_in = 1'b0;
    g_host_valid = 1'b0; g_host_din = 32'h0; g_credit_in = 1'b0;

    // Single packet, credits tied low: 4 flits, stall, then the 5th after one credit.
    reset_a();
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1; host_din = 32'h11 + 32'(i);
      step();
    end
    host_valid = 1'b0; host_din = 32'h0;
    step();
    for (int j = 0; j < 4; j++) begin
      check_eq("single_flit", channel_dout, 32'h11 + 32'(j));
      step();
    end
    for (int j = 0; j < 3; j++) begin
      check_eq("single_stall", channel_dout, 32'h0);
      step();
    end
    check_eq("single_pkts0", 32'(packets_sent), 32'd0);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check_eq("single_wait", channel_dout, 32'h0);
    step();
    check_eq("single_last", channel_dout, 32'h15);
    check_eq("single_pkts1", 32'(packets_sent), 32'd1);
    step();
    check_eq("single_idle", channel_dout, 32'h0);
    check_eq("single_busy", 32'(busy), 32'd0);

    // Partial packet is held until its fifth flit arrives.
    reset_a();
    credit_en = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(32'h21 + 32'(i));
    repeat (24) cycle_a();
    check_eq("partial_hold", 32'(rx_total), 32'd0);
    check_eq("partial_busy", 32'(busy), 32'd1);
    src_q.push_back(32'h25);
    run_until_rx(5, 30);
    check_eq("partial_rx", 32'(rx_total), 32'd5);
    repeat (2) cycle_a();
    check_eq("partial_pkts", 32'(packets_sent), 32'd1);

    // Back-to-back packets with ample credits: exactly one idle cycle between them.
    reset_a();
    credit_en = 1'b1;
    for (int i = 0; i < 10; i++) src_q.push_back(32'h81 + 32'(i));
    run_until_rx(10, 100);
    check_eq("tput_rx", 32'(rx_total), 32'd10);
    while (rx_time.size() < 10) rx_time.push_back(0);
    check_eq("tput_burst", 32'(rx_time[4] - rx_time[0]), 32'd4);
    check_eq("tput_spacing", 32'(rx_time[5] - rx_time[4]), 32'd2);
    check_eq("tput_pkts", 32'(packets_sent), 32'd2);

    // FIFO full: drain credits to zero, then push 8+5 flits.
    reset_a();
    for (int i = 0; i < 5; i++) src_q.push_back(32'h31 + 32'(i));
    repeat (12) cycle_a();
    check_eq("drain_stall", 32'(rx_total), 32'd4);
    ret_pend = 1;
    repeat (5) cycle_a();
    check_eq("drain_done", 32'(rx_total), 32'd5);
    acc_total = 0;
    for (int i = 0; i < 13; i++) src_q.push_back(32'h41 + 32'(i));
    repeat (8) cycle_a();
    check_eq("full_accepted", 32'(acc_total), 32'd8);
    check_eq("full_ready", 32'(host_ready), 32'd0);
    repeat (6) cycle_a();
    check_eq("full_hold", 32'(acc_total), 32'd8);
    check_eq("full_no_send", 32'(rx_total), 32'd5);
    credit_en = 1'b1;
    ret_pend = 4;
    run_until_rx(15, 120);
    repeat (10) cycle_a();
    check_eq("full_rx", 32'(rx_total), 32'd15);
    check_eq("full_acc", 32'(acc_total), 32'd13);
    check_eq("full_pkts", 32'(packets_sent), 32'd3);
    check_eq("full_busy", 32'(busy), 32'd1);

    // Credit overflow at reset state is flagged, sticky, and grants no extra flit.
    reset_a();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check_eq("ovf_err", 32'(credit_error), 32'd1);
    repeat (3) step();
    check_eq("ovf_sticky", 32'(credit_error), 32'd1);
    for (int i = 0; i < 5; i++) src_q.push_back(32'h51 + 32'(i));
    repeat (16) cycle_a();
    check_eq("ovf_limit", 32'(rx_total), 32'd4);
    check_eq("ovf_still", 32'(credit_error), 32'd1);

    // Reset mid-packet discards the partial packet and restores credits.
    reset_a();
    credit_en = 1'b1;
    for (int i = 0; i < 5; i++) src_q.push_back(32'h61 + 32'(i));
    run_until_rx(2, 20);
    check_eq("mid_rx2", 32'(rx_total), 32'd2);
    reset_a();
    for (int i = 0; i < 5; i++) src_q.push_back(32'h71 + 32'(i));
    repeat (12) cycle_a();
    check_eq("mid_credits", 32'(rx_total), 32'd4);
    credit_en = 1'b1;
    ret_pend = 4;
    run_until_rx(5, 20);
    cycle_a();
    check_eq("mid_rx", 32'(rx_total), 32'd5);
    check_eq("mid_pkts", 32'(packets_sent), 32'd1);

    // Randomized host valid and credit return delays.
    for (int r = 0; r < 2; r++) begin
      reset_a();
      credit_en = 1'b1; rand_valid = 1'b1; rand_cred = 1'b1;
      for (int i = 0; i < 40; i++) src_q.push_back(32'($urandom) | 32'h1);
      run_until_rx(40, 3000);
      repeat (6) cycle_a();
      check_eq("rand_rx", 32'(rx_total), 32'd40);
      check_eq("rand_pkts", 32'(packets_sent), 32'd8);
      check_eq("rand_busy", 32'(busy), 32'd0);
      check_eq("rand_err", 32'(credit_error), 32'd0);
    end

    // Gap enforcement on the GAP_CYCLES=3 instance.
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check_eq("gap_rst_dout", g_channel_dout, 32'h0);
    check_eq("gap_rst_busy", 32'(g_busy), 32'd0);
    pushed = 0; seen = 0; retq = 0;
    for (int i = 0; i < 10; i++) begin
      g_t[i] = 0;
      g_v[i] = 0;
    end
    for (int c = 0; c < 60; c++) begin
      g_host_valid = (pushed < 10);
      g_host_din   = 32'hA0 + 32'(pushed);
      g_credit_in  = (retq > 0);
      if (retq > 0) retq--;
      if (g_host_valid && g_host_ready) pushed++;
      step();
      if (g_channel_dout != 32'h0) begin
        if (seen < 10) begin
          g_t[seen] = c;
          g_v[seen] = int'(g_channel_dout);
        end
        seen++;
        retq++;
      end
    end
    g_host_valid = 1'b0; g_credit_in = 1'b0;
    check_eq("gap_seen", 32'(seen), 32'd10);
    for (int i = 0; i < 10; i++) check_eq("gap_order", 32'(g_v[i]), 32'hA0 + 32'(i));
    check_eq("gap_burst1", 32'(g_t[4] - g_t[0]), 32'd4);
    check_eq("gap_zeros", 32'(g_t[5] - g_t[4] - 1), 32'd4);
    check_eq("gap_burst2", 32'(g_t[9] - g_t[5]), 32'd4);
    check_eq("gap_pkts", 32'(g_packets_sent), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule
